// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, requester IDs and write-transaction type for reg_file_wr_arbiter
package rf_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef enum logic {REQ_ALU = 1'b0, REQ_LOAD = 1'b1} req_id_e;
  typedef struct packed {
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
  } wr_txn_t;
endpackage

// File: rtl/rf_rr_arbiter.sv
// rf_rr_arbiter: 2-way grant (round-robin PRI under RF_ARB_RR_EN, else fixed req0) + LAST_GRANT; ports clk,rst_n,hold_i,valid_i[1:0] -> ready_o[1:0],last_o
module rf_rr_arbiter
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold_i,
  input  logic [1:0] valid_i,
  output logic [1:0] ready_o,
  output req_id_e    last_o
);
  logic [1:0] grant;
  req_id_e last_q, last_d;
`ifdef RF_ARB_RR_EN
  logic pri_q, pri_d;
  assign grant = &valid_i ? (pri_q ? 2'b10 : 2'b01) : valid_i;
  assign pri_d = |ready_o ? ready_o[0] : pri_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pri_q <= 1'b0;
    else pri_q <= pri_d;
`else
  assign grant = valid_i[0] ? 2'b01 : valid_i;
`endif
  assign ready_o = (hold_i || !rst_n) ? 2'b00 : grant;
  assign last_d = |ready_o ? req_id_e'(ready_o[1]) : last_q;
  assign last_o = last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= REQ_ALU;
    else last_q <= last_d;
endmodule

// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter: 2-requester valid/ready arbiter driving a registered RF write port + BUSY mask; ports HOLD,REQ{0,1}_{VALID,READY,SEL,DATA},WR_{EN,SEL,DATA},BUSY,LAST_GRANT; RF_ARB_RR_EN selects round-robin
module reg_file_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 HOLD,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [ADDR_W-1:0]    REQ0_SEL,
  input  logic [DATA_W-1:0]    REQ0_DATA,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [ADDR_W-1:0]    REQ1_SEL,
  input  logic [DATA_W-1:0]    REQ1_DATA,
  output logic                 WR_EN,
  output logic [ADDR_W-1:0]    WR_SEL,
  output logic [DATA_W-1:0]    WR_DATA,
  output logic [2**ADDR_W-1:0] BUSY,
  output logic                 LAST_GRANT
);
  localparam int NR = 2 ** ADDR_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  logic [1:0] ready;
  req_id_e last;
  logic [0:0] state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  rf_rr_arbiter u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (HOLD),
    .valid_i({REQ1_VALID, REQ0_VALID}),
    .ready_o(ready),
    .last_o (last)
  );
  assign REQ0_READY = ready[0];
  assign REQ1_READY = ready[1];
  assign LAST_GRANT = last;
  always_comb begin
    state_d = |ready ? WRITE : IDLE;
    sel_d = ready[1] ? REQ1_SEL : ready[0] ? REQ0_SEL : sel_q;
    data_d = ready[1] ? REQ1_DATA : ready[0] ? REQ0_DATA : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      data_q <= data_d;
    end
  assign WR_EN = state_q == WRITE;
  assign WR_SEL = sel_q;
  assign WR_DATA = data_q;
  assign BUSY = WR_EN ? {{(NR-1){1'b0}}, 1'b1} << WR_SEL : '0;
endmodule
